// File: rtl/brick_pkg.sv
// Shared constants, FSM encodings and small arithmetic helpers for the brick
// health writer.
package brick_pkg;

  localparam int NUM_BRICKS = 40;
  localparam int IDX_W      = 6;
  localparam int HP_W       = 2;
  localparam int HEALTH_W   = 10;

  localparam logic [HEALTH_W-1:0] HEALTH_MAX = 10'd1023;
  localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(NUM_BRICKS - 1);

  // FSM encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_INIT = 2'd1;
  localparam logic [1:0] ST_RD   = 2'd2;
  localparam logic [1:0] ST_MOD  = 2'd3;

  // Add a brick's health to the running level total, clamping at HEALTH_MAX.
  function automatic logic [HEALTH_W-1:0] sat_add(
    input logic [HEALTH_W-1:0] acc,
    input logic [HP_W-1:0]     hp
  );
    logic [HEALTH_W:0] sum;
    sum = {1'b0, acc} + {{(HEALTH_W + 1 - HP_W){1'b0}}, hp};
    if (sum[HEALTH_W] == 1'b1) begin
      return HEALTH_MAX;
    end else begin
      return sum[HEALTH_W-1:0];
    end
  endfunction

  // True when a collision index names a real brick.
  function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
    return (idx <= LAST_IDX);
  endfunction

endpackage

// File: rtl/brick_hit_writer.sv
// Brick health writer: loads a level into the external brick RAM, publishes
// the level's total health, then applies collision hits by read-modify-write,
// pulsing game_write once for every health point actually removed.
module brick_hit_writer
  import brick_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                init_start,
  input  logic [HP_W-1:0]     init_hp,
  output logic                init_done,
  output logic [HEALTH_W-1:0] total_health,
  input  logic                hit_valid,
  input  logic [IDX_W-1:0]    hit_idx,
  output logic                hit_ready,
  output logic [IDX_W-1:0]    mem_rd_addr,
  input  logic [HP_W-1:0]     mem_rd_data,
  output logic                mem_wr_en,
  output logic [IDX_W-1:0]    mem_wr_addr,
  output logic [HP_W-1:0]     mem_wr_data,
  output logic                game_write,
  output logic                brick_destroyed,
  output logic [IDX_W-1:0]    destroyed_idx,
  output logic                busy
);

  localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [HP_W-1:0]  HP_ONE  = {{(HP_W-1){1'b0}}, 1'b1};
  localparam logic [HP_W-1:0]  HP_ZERO = {HP_W{1'b0}};

  logic [1:0]          state;
  logic [1:0]          next_state;
  logic [IDX_W-1:0]    init_ctr;
  logic [HP_W-1:0]     init_hp_q;
  logic [HEALTH_W-1:0] total_q;
  // Latched hit index; it is also the RAM read address, so it is presented
  // during RD and simply holds its value whenever no read is wanted.
  logic [IDX_W-1:0]    hit_idx_q;
  logic                accept_hit;
  logic                start_init;

  // The RAM read address and the level total come straight from registers.
  assign mem_rd_addr  = hit_idx_q;
  assign total_health = total_q;

  // Next-state and per-cycle RAM/pulse outputs; reset forces every strobe low
  // so an interrupted INIT or MOD cycle never reaches the RAM.
  always_comb begin
    next_state      = state;
    mem_wr_en       = 1'b0;
    mem_wr_addr     = {IDX_W{1'b0}};
    mem_wr_data     = HP_ZERO;
    game_write      = 1'b0;
    brick_destroyed = 1'b0;
    destroyed_idx   = {IDX_W{1'b0}};
    init_done       = 1'b0;
    hit_ready       = 1'b0;
    busy            = 1'b0;
    accept_hit      = 1'b0;
    start_init      = 1'b0;
    if (reset) begin
      next_state = ST_IDLE;
    end else begin
      busy = (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          // A level load always wins over a pending hit in the same cycle.
          hit_ready = ~init_start;
          if (init_start) begin
            start_init = 1'b1;
            next_state = ST_INIT;
          end else if (hit_valid) begin
            accept_hit = 1'b1;
            if (idx_in_range(hit_idx)) begin
              next_state = ST_RD;
            end else begin
              // Out-of-range hit is consumed but never touches the RAM.
              next_state = ST_IDLE;
            end
          end else begin
            next_state = ST_IDLE;
          end
        end
        ST_INIT: begin
          mem_wr_en   = 1'b1;
          mem_wr_addr = init_ctr;
          mem_wr_data = init_hp_q;
          if (init_ctr == LAST_IDX) begin
            init_done  = 1'b1;
            next_state = ST_IDLE;
          end else begin
            next_state = ST_INIT;
          end
        end
        ST_RD: begin
          next_state = ST_MOD;
        end
        ST_MOD: begin
          next_state = ST_IDLE;
          if (mem_rd_data != HP_ZERO) begin
            mem_wr_en   = 1'b1;
            mem_wr_addr = hit_idx_q;
            mem_wr_data = mem_rd_data - HP_ONE;
            game_write  = 1'b1;
            if (mem_rd_data == HP_ONE) begin
              brick_destroyed = 1'b1;
              destroyed_idx   = hit_idx_q;
            end else begin
              brick_destroyed = 1'b0;
            end
          end else begin
            // Already-dead brick: nothing to remove, nothing to report.
            mem_wr_en = 1'b0;
          end
        end
        default: begin
          next_state = ST_IDLE;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // INIT address counter and the health value captured for this level load.
  always_ff @(posedge clk) begin
    if (reset) begin
      init_ctr  <= {IDX_W{1'b0}};
      init_hp_q <= HP_ZERO;
    end else if (start_init) begin
      init_ctr  <= {IDX_W{1'b0}};
      init_hp_q <= init_hp;
    end else if (state == ST_INIT) begin
      init_ctr  <= init_ctr + IDX_ONE;
    end else begin
      init_ctr  <= init_ctr;
    end
  end

  // Level total: cleared on a new load, grows by one brick per INIT write.
  always_ff @(posedge clk) begin
    if (reset) begin
      total_q <= {HEALTH_W{1'b0}};
    end else if (start_init) begin
      total_q <= {HEALTH_W{1'b0}};
    end else if (state == ST_INIT) begin
      total_q <= sat_add(total_q, init_hp_q);
    end else begin
      total_q <= total_q;
    end
  end

  // Capture the index of an accepted, in-range hit for the RD/MOD pass.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_idx_q <= {IDX_W{1'b0}};
    end else if (accept_hit && idx_in_range(hit_idx)) begin
      hit_idx_q <= hit_idx;
    end else begin
      hit_idx_q <= hit_idx_q;
    end
  end

endmodule

// File: tb/tb_brick_hit_writer.sv
// Directed bench for brick_hit_writer with a behavioural 1-cycle-read brick RAM.
`timescale 1ns/1ps
module tb_brick_hit_writer;
  import brick_pkg::*;

  logic                clk;
  logic                reset;
  logic                init_start;
  logic [HP_W-1:0]     init_hp;
  logic                init_done;
  logic [HEALTH_W-1:0] total_health;
  logic                hit_valid;
  logic [IDX_W-1:0]    hit_idx;
  logic                hit_ready;
  logic [IDX_W-1:0]    mem_rd_addr;
  logic [HP_W-1:0]     mem_rd_data;
  logic                mem_wr_en;
  logic [IDX_W-1:0]    mem_wr_addr;
  logic [HP_W-1:0]     mem_wr_data;
  logic                game_write;
  logic                brick_destroyed;
  logic [IDX_W-1:0]    destroyed_idx;
  logic                busy;

  int tests_run    = 0;
  int tests_failed = 0;

  brick_hit_writer dut (
    .clk(clk), .reset(reset), .init_start(init_start), .init_hp(init_hp),
    .init_done(init_done), .total_health(total_health), .hit_valid(hit_valid),
    .hit_idx(hit_idx), .hit_ready(hit_ready), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .game_write(game_write),
    .brick_destroyed(brick_destroyed), .destroyed_idx(destroyed_idx), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Brick RAM model: synchronous read, read-before-write.
  logic [HP_W-1:0] ram [0:63];
  always @(posedge clk) begin
    mem_rd_data <= ram[mem_rd_addr];
    if (mem_wr_en) ram[mem_wr_addr] <= mem_wr_data;
  end

  // Event monitor: counts game_write pulses and records hit accept cycles.
  int cycle_cnt = 0;
  int gw_count  = 0;
  int acc_cnt   = 0;
  int acc_cyc [0:15];
  always @(posedge clk) begin
    cycle_cnt <= cycle_cnt + 1;
    if (game_write) gw_count <= gw_count + 1;
    if (hit_valid && hit_ready) begin
      if (acc_cnt < 16) acc_cyc[acc_cnt] <= cycle_cnt;
      acc_cnt <= acc_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Full hit transaction on a given brick with the expected MOD outcome.
  task automatic do_hit(input logic [IDX_W-1:0] idx, input logic exp_wr,
                        input logic [HP_W-1:0] exp_data, input logic exp_dest);
    cyc();
    hit_valid = 1'b1;
    hit_idx   = idx;
    #3 check("hit_ready_accept", 32'(hit_ready), 32'd1);
    cyc();
    hit_valid = 1'b0;
    #3;
    check("rd_busy", 32'(busy), 32'd1);
    check("rd_addr", 32'(mem_rd_addr), 32'(idx));
    check("rd_no_write", 32'(mem_wr_en), 32'd0);
    cyc();
    #3;
    check("mod_wr_en", 32'(mem_wr_en), 32'(exp_wr));
    check("mod_game_write", 32'(game_write), 32'(exp_wr));
    check("mod_destroyed", 32'(brick_destroyed), 32'(exp_dest));
    if (exp_wr) begin
      check("mod_wr_addr", 32'(mem_wr_addr), 32'(idx));
      check("mod_wr_data", 32'(mem_wr_data), 32'(exp_data));
    end
    if (exp_dest) check("mod_destroyed_idx", 32'(destroyed_idx), 32'(idx));
    cyc();
    #3 check("hit_ready_after", 32'(hit_ready), 32'd1);
  endtask

  // Run a level load with hp per brick; optionally also present a hit in the start cycle.
  task automatic do_init(input logic [HP_W-1:0] hp, input logic with_hit,
                         input logic [31:0] exp_total);
    cyc();
    init_start = 1'b1;
    init_hp    = hp;
    hit_valid  = with_hit;
    hit_idx    = 6'd6;
    #3 check("init_start_ready", 32'(hit_ready), 32'd0);
    for (int i = 0; i < NUM_BRICKS; i++) begin
      cyc();
      init_start = 1'b0;
      hit_valid  = 1'b0;
      #3;
      check("init_wr_en", 32'(mem_wr_en), 32'd1);
      check("init_wr_addr", 32'(mem_wr_addr), 32'(i));
      check("init_wr_data", 32'(mem_wr_data), 32'(hp));
      check("init_done", 32'(init_done), (i == NUM_BRICKS - 1) ? 32'd1 : 32'd0);
      check("init_busy", 32'(busy), 32'd1);
    end
    cyc();
    #3;
    check("total_health", 32'(total_health), exp_total);
    check("init_done_clear", 32'(init_done), 32'd0);
    check("init_idle_ready", 32'(hit_ready), 32'd1);
  endtask

  int gw0;

  initial begin
    reset      = 1'b1;
    init_start = 1'b0;
    init_hp    = 2'd0;
    hit_valid  = 1'b0;
    hit_idx    = 6'd0;

    // Reset state
    cyc();
    cyc();
    #3;
    check("rst_total", 32'(total_health), 32'd0);
    check("rst_wr_en", 32'(mem_wr_en), 32'd0);
    check("rst_ready", 32'(hit_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_addr", 32'(mem_rd_addr), 32'd0);
    cyc();
    reset = 1'b0;
    #3 check("ready_after_rst", 32'(hit_ready), 32'd1);

    // 1: level load with hp=3 -> total 120
    do_init(2'd3, 1'b0, 32'd120);
    check("ram5_after_init", 32'(ram[5]), 32'd3);

    // 2: brick 5 hit four times
    gw0 = gw_count;
    do_hit(6'd5, 1'b1, 2'd2, 1'b0);
    do_hit(6'd5, 1'b1, 2'd1, 1'b0);
    do_hit(6'd5, 1'b1, 2'd0, 1'b1);
    do_hit(6'd5, 1'b0, 2'd0, 1'b0);
    check("gw_count_brick5", 32'(gw_count - gw0), 32'd3);
    check("ram5_dead", 32'(ram[5]), 32'd0);

    // 3: out-of-range index dropped
    gw0 = gw_count;
    cyc();
    hit_valid = 1'b1;
    hit_idx   = 6'd45;
    #3 check("oor_ready", 32'(hit_ready), 32'd1);
    cyc();
    hit_valid = 1'b0;
    #3;
    check("oor_busy", 32'(busy), 32'd0);
    check("oor_ready_next", 32'(hit_ready), 32'd1);
    check("oor_wr_en", 32'(mem_wr_en), 32'd0);
    check("oor_rd_addr_held", 32'(mem_rd_addr), 32'd5);
    cyc();
    #3 check("oor_gw", 32'(gw_count - gw0), 32'd0);

    // 4: init_start and hit together -> INIT wins, hp=2 -> total 80
    gw0 = gw_count;
    do_init(2'd2, 1'b1, 32'd80);
    check("collide_gw", 32'(gw_count - gw0), 32'd0);
    check("ram6_untouched", 32'(ram[6]), 32'd2);
    check("ram5_reloaded", 32'(ram[5]), 32'd2);

    // 6: hold hit_valid on brick 7 (hp=2) for 12 cycles
    gw0 = gw_count;
    acc_cnt = 0;
    cyc();
    hit_valid = 1'b1;
    hit_idx   = 6'd7;
    repeat (12) cyc();
    hit_valid = 1'b0;
    repeat (3) cyc();
    #3;
    check("hold_accepts", 32'(acc_cnt), 32'd4);
    check("hold_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
    check("hold_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
    check("hold_gap3", 32'(acc_cyc[3] - acc_cyc[2]), 32'd3);
    check("hold_gw", 32'(gw_count - gw0), 32'd2);
    check("ram7_dead", 32'(ram[7]), 32'd0);

    // 5: reset asserted during MOD on brick 8 (hp=2)
    gw0 = gw_count;
    cyc();
    hit_valid = 1'b1;
    hit_idx   = 6'd8;
    cyc();
    hit_valid = 1'b0;
    cyc();
    reset = 1'b1;
    #3;
    check("mod_rst_wr_en", 32'(mem_wr_en), 32'd0);
    check("mod_rst_gw", 32'(game_write), 32'd0);
    cyc();
    reset = 1'b0;
    #3;
    check("mod_rst_idle", 32'(busy), 32'd0);
    check("mod_rst_ready", 32'(hit_ready), 32'd1);
    check("mod_rst_total", 32'(total_health), 32'd0);
    check("ram8_kept", 32'(ram[8]), 32'd2);
    check("mod_rst_gw_cnt", 32'(gw_count - gw0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
